// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: sequencer for the AES-128 encryption round-step units.
// Drives SubBytes / ShiftRows / MixColumns / AddRoundKey through their
// enable/finished handshakes in FIPS-197 order, tracks the round number for
// the key schedule and guards every wait with a watchdog.
// Outputs are registered from the next-state decode, so each output matches
// the state register that is loaded on the same edge.
module aes_round_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_clear,
  input  logic       i_sbytes_finished,
  input  logic       i_srows_finished,
  input  logic       i_mcols_finished,
  input  logic       i_ark_finished,
  output logic       o_sbytes_enable,
  output logic       o_srows_enable,
  output logic       o_mcols_enable,
  output logic       o_ark_enable,
  output logic [3:0] o_round_num,
  output logic       o_last_round,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error
);

  localparam int              WD_W     = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);
  localparam logic [WD_W-1:0] WD_ZERO  = WD_W'(0);
  localparam logic [3:0]      LAST_RND = 4'(NUM_ROUNDS);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ARK0_EN   = 4'd1,
    ST_ARK0_WAIT = 4'd2,
    ST_SB_EN     = 4'd3,
    ST_SB_WAIT   = 4'd4,
    ST_SR_EN     = 4'd5,
    ST_SR_WAIT   = 4'd6,
    ST_MC_EN     = 4'd7,
    ST_MC_WAIT   = 4'd8,
    ST_ARK_EN    = 4'd9,
    ST_ARK_WAIT  = 4'd10,
    ST_DONE      = 4'd11,
    ST_ERR       = 4'd12
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [3:0]        r_round_num;
  logic [3:0]        w_round_nxt;
  logic [WD_W-1:0]   r_wdog;
  logic [WD_W-1:0]   w_wdog_nxt;
  logic              w_wait_fin;
  logic              w_timeout;
  logic              w_busy_st;

  logic              w_sb_en_nxt;
  logic              w_sr_en_nxt;
  logic              w_mc_en_nxt;
  logic              w_ark_en_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic              w_error_nxt;
  logic              w_last_nxt;

  assign w_timeout   = (r_wdog == WD_LAST);
  assign w_busy_st   = !((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign o_round_num = r_round_num;

  // Select the finished pulse belonging to the unit the current WAIT state serves.
  always_comb begin
    w_wait_fin = 1'b0;
    case (r_state)
      ST_ARK0_WAIT: w_wait_fin = i_ark_finished;
      ST_SB_WAIT:   w_wait_fin = i_sbytes_finished;
      ST_SR_WAIT:   w_wait_fin = i_srows_finished;
      ST_MC_WAIT:   w_wait_fin = i_mcols_finished;
      ST_ARK_WAIT:  w_wait_fin = i_ark_finished;
      default:      w_wait_fin = 1'b0;
    endcase
  end

  // State, round counter and watchdog registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= ST_IDLE;
      r_round_num <= 4'd0;
      r_wdog      <= WD_ZERO;
    end else begin
      r_state     <= w_next_state;
      r_round_num <= w_round_nxt;
      r_wdog      <= w_wdog_nxt;
    end
  end

  // Next-state, next-round and watchdog update; abort overrides finished and timeout.
  always_comb begin
    w_next_state = r_state;
    w_round_nxt  = r_round_num;
    w_wdog_nxt   = WD_ZERO;
    if (w_busy_st && i_abort) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_next_state = ST_ARK0_EN;
            w_round_nxt  = 4'd0;
          end else begin
            w_next_state = ST_IDLE;
          end
        end
        ST_ARK0_EN: w_next_state = ST_ARK0_WAIT;
        ST_SB_EN:   w_next_state = ST_SB_WAIT;
        ST_SR_EN:   w_next_state = ST_SR_WAIT;
        ST_MC_EN:   w_next_state = ST_MC_WAIT;
        ST_ARK_EN:  w_next_state = ST_ARK_WAIT;
        ST_ARK0_WAIT, ST_SB_WAIT, ST_SR_WAIT, ST_MC_WAIT, ST_ARK_WAIT: begin
          if (w_wait_fin) begin
            case (r_state)
              ST_ARK0_WAIT: begin
                w_next_state = ST_SB_EN;
                w_round_nxt  = r_round_num + 4'd1;
              end
              ST_SB_WAIT: w_next_state = ST_SR_EN;
              ST_SR_WAIT: begin
                // The final round has no MixColumns step.
                if (r_round_num == LAST_RND) begin
                  w_next_state = ST_ARK_EN;
                end else begin
                  w_next_state = ST_MC_EN;
                end
              end
              ST_MC_WAIT: w_next_state = ST_ARK_EN;
              ST_ARK_WAIT: begin
                if (r_round_num == LAST_RND) begin
                  w_next_state = ST_DONE;
                end else begin
                  w_next_state = ST_SB_EN;
                  w_round_nxt  = r_round_num + 4'd1;
                end
              end
              default: w_next_state = ST_IDLE;
            endcase
          end else if (w_timeout) begin
            w_next_state = ST_ERR;
          end else begin
            w_next_state = r_state;
            w_wdog_nxt   = r_wdog + WD_ONE;
          end
        end
        ST_DONE: w_next_state = ST_IDLE;
        ST_ERR: begin
          if (i_clear) begin
            w_next_state = ST_IDLE;
          end else begin
            w_next_state = ST_ERR;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Moore output decode of the state about to be loaded.
  always_comb begin
    w_sb_en_nxt  = 1'b0;
    w_sr_en_nxt  = 1'b0;
    w_mc_en_nxt  = 1'b0;
    w_ark_en_nxt = 1'b0;
    w_busy_nxt   = 1'b1;
    w_done_nxt   = 1'b0;
    w_error_nxt  = 1'b0;
    w_last_nxt   = (w_round_nxt == LAST_RND);
    case (w_next_state)
      ST_IDLE:    w_busy_nxt   = 1'b0;
      ST_ARK0_EN: w_ark_en_nxt = 1'b1;
      ST_SB_EN:   w_sb_en_nxt  = 1'b1;
      ST_SR_EN:   w_sr_en_nxt  = 1'b1;
      ST_MC_EN:   w_mc_en_nxt  = 1'b1;
      ST_ARK_EN:  w_ark_en_nxt = 1'b1;
      ST_DONE: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
      end
      ST_ERR: begin
        w_busy_nxt  = 1'b0;
        w_error_nxt = 1'b1;
      end
      default: w_busy_nxt = 1'b1;
    endcase
  end

  // Output registers, loaded alongside the state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_sbytes_enable <= 1'b0;
      o_srows_enable  <= 1'b0;
      o_mcols_enable  <= 1'b0;
      o_ark_enable    <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_error         <= 1'b0;
      o_last_round    <= 1'b0;
    end else begin
      o_sbytes_enable <= w_sb_en_nxt;
      o_srows_enable  <= w_sr_en_nxt;
      o_mcols_enable  <= w_mc_en_nxt;
      o_ark_enable    <= w_ark_en_nxt;
      o_busy          <= w_busy_nxt;
      o_done          <= w_done_nxt;
      o_error         <= w_error_nxt;
      o_last_round    <= w_last_nxt;
    end
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Sequencer for the AES-128 encryption datapath. On `start` it drives the four round-step units (SubBytes, ShiftRows, MixColumns, AddRoundKey) through their enable/finished handshakes in FIPS-197 order, tracks the round number for the key schedule, and flags completion. Each step unit is a registered block that returns a one-cycle `*_finished` pulse after a one-cycle `*_enable` pulse. A watchdog catches units that never respond.

## Interface
- `NUM_ROUNDS`, default 10: total rounds after the initial AddRoundKey; legal range 2..14.
- `TIMEOUT`, default 16: maximum cycles spent in one WAIT state before declaring error; legal range ≥1.

- `clk`  in  1  clock, rising edge.
- `n_rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin encryption; sampled only in IDLE.
- `abort`  in  1  cancel an operation in progress; return to IDLE.
- `clear`  in  1  leave ERR state.
- `sbytes_finished`, `srows_finished`, `mcols_finished`, `ark_finished`  in  1 each  completion pulses from the step units.
- `sbytes_enable`, `srows_enable`, `mcols_enable`, `ark_enable`  out  1 each  one-cycle step start pulses.
- `round_num`  out  4  current round, 0..NUM_ROUNDS.
- `last_round`  out  1  high while `round_num == NUM_ROUNDS`.
- `busy`  out  1  high in every state except IDLE, DONE and ERR.
- `done`  out  1  one-cycle pulse on completion.
- `error`  out  1  high while in ERR.

## Operation
- Moore FSM with states IDLE, ARK0_EN, ARK0_WAIT, SB_EN, SB_WAIT, SR_EN, SR_WAIT, MC_EN, MC_WAIT, ARK_EN, ARK_WAIT, DONE, ERR. All outputs decode from registered state and counters.
- IDLE:
  - `start=1` → ARK0_EN.
  - `round_num` is cleared to 0 on this transition.
- Each *_EN state asserts its enable for exactly one cycle, then unconditionally moves to the matching *_WAIT state.
- Each *_WAIT state samples only its own unit's finished signal.
  - Finished=1 → next step.
  - Finished from other units is ignored.
  - Finished during an *_EN state is ignored.
- Step order:
  - ARK0_WAIT → SB_EN, with `round_num` incremented to 1.
  - SB_WAIT → SR_EN.
  - SR_WAIT → MC_EN if `round_num < NUM_ROUNDS`.
  - SR_WAIT → ARK_EN if `round_num == NUM_ROUNDS` (final round skips MixColumns).
  - MC_WAIT → ARK_EN.
  - ARK_WAIT → DONE if `round_num == NUM_ROUNDS`; otherwise → SB_EN, with `round_num` incremented.
- DONE: `done=1` for one cycle, then → IDLE. `round_num` holds NUM_ROUNDS until the next start.
- Watchdog:
  - The counter, of width clog2(TIMEOUT+1), clears on every entry to a WAIT state.
  - It increments on each WAIT cycle in which finished is not seen.
  - WAIT cycle number TIMEOUT without finished → ERR. A finished pulse on that same cycle is accepted instead.
- ERR: `error=1`, all enables 0, `round_num` frozen. `clear=1` → IDLE. `start` is ignored in ERR.
- `abort=1` in any busy state → IDLE next cycle. No enable is issued and no `done` pulse is produced. `abort` has priority over finished and timeout.
- `start` while busy, in DONE or in ERR is ignored.

## Timing
- Reset values: state IDLE, `round_num=0`, watchdog 0. All enables, `busy`, `done`, `error` and `last_round` are 0.
- Each step costs 1 EN cycle plus N WAIT cycles, where N is 1..TIMEOUT. With single-cycle-response units N=1, so each step takes 2 cycles.
- Latency example for `start` high in IDLE at cycle T, with NUM_ROUNDS=10 and N=1:
  - ARK0_EN at T+1.
  - 40 steps (1 + 9×4 + 3) occupy T+1..T+80.
  - `done` is high at T+81 and IDLE is reached at T+82.
  - `start` is accepted again from T+82.
- `round_num` changes on the edge leaving ARK0_WAIT or ARK_WAIT. It is stable for the whole round, including the round's ARK, so the key schedule can index on it.
- At most one enable is high in any cycle.
- Reset mid-operation forces the reset values immediately, asynchronously.

## Test plan
- Reset, then `start` for 1 cycle; every unit responds 1 cycle after enable:
  - Enable order is ark, then (sb, sr, mc, ark)×9, then sb, sr, ark.
  - `done` fires at T+81.
  - `round_num` steps 0→10.
  - `last_round` is high only during round 10.
- Random unit response delays of 1..TIMEOUT WAIT cycles:
  - Sequence is identical to the previous case.
  - Exactly 40 enable pulses occur.
  - Exactly one `done` pulse occurs.
- Withhold `mcols_finished` in round 3:
  - After 16 WAIT cycles, `error=1`, `busy=0`, and `round_num=3`.
  - `clear` returns the block to IDLE.
  - A subsequent run completes normally.
- Assert `abort` during SR_WAIT of round 5:
  - Block is in IDLE the next cycle.
  - No `done` and no further enables.
  - `start` works afterwards.
- Spurious `ark_finished` during SB_WAIT, and `start` pulses mid-run: both are ignored, and timing matches the first case.
- NUM_ROUNDS=14: 56 steps and `done` at T+113; boundary finished pulse on WAIT cycle 16 with TIMEOUT=16 is accepted without error.
